// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources.
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wb_hold,
    output logic                        reg_write,
    output logic [ADDR_W-1:0]           write_reg,
    output logic [DATA_W-1:0]           write_data,
    output logic [CNT_W-1:0]            conflict_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [PTR_W-1:0]   scan_base;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] grant;
    int                 scan_idx;
    int                 n_valid;
    logic               conflict;

    // Scan from the pointer upward, wrapping, and stop at the first valid requester.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = 0;
        if (rst_n && !wb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = int'(scan_base) + k;
                if (scan_idx >= NUM_REQ) begin
                    scan_idx = scan_idx - NUM_REQ;
                end
                if (!gnt_any && req_valid[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PTR_W'(scan_idx);
                end
            end
            grant[gnt_idx] = gnt_any;
        end
    end

    assign req_ready = grant;

`ifdef WB_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    assign scan_base = ptr_reg;

    always_comb begin
        ptr_next = ptr_reg;
        if (gnt_any) begin
            ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`endif

    always_comb begin
        n_valid = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            n_valid = n_valid + int'(req_valid[k]);
        end
        conflict = (n_valid >= 2);
    end

    // Register-0 requests still consume the grant; only the write enable is suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (gnt_any) begin
            reg_write  <= (addr_arr[gnt_idx] != '0);
            write_reg  <= addr_arr[gnt_idx];
            write_data <= data_arr[gnt_idx];
        end else begin
            reg_write  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus async-reset and counter-saturation sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_hold;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [15:0] conflict_cnt;

    logic [2:0]  sat_valid;
    logic [14:0] sat_addr;
    logic [95:0] sat_data;
    logic [2:0]  sat_ready;
    logic        sat_hold;
    logic        sat_rw;
    logic [4:0]  sat_wr;
    logic [31:0] sat_wd;
    logic [3:0]  sat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_hold      (wb_hold),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .conflict_cnt (conflict_cnt)
    );

    regfile_wb_arbiter #(.CNT_W(4)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (sat_valid),
        .req_addr     (sat_addr),
        .req_data     (sat_data),
        .req_ready    (sat_ready),
        .wb_hold      (sat_hold),
        .reg_write    (sat_rw),
        .write_reg    (sat_wr),
        .write_data   (sat_wd),
        .conflict_cnt (sat_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic        hold;
        logic [2:0]  ready;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [15:0] cnt;
    } vec_t;

    localparam logic [14:0] A123 = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] D123 = {32'h33, 32'h22, 32'h11};

    vec_t vec [18];

    // Requester-rule monitor: a request left waiting must keep addr/data until granted.
    logic [2:0]  pend = '0;
    logic [14:0] prev_addr;
    logic [95:0] prev_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i] && req_valid[i]) begin
                    n_checks++;
                    if (req_addr[i*5 +: 5] !== prev_addr[i*5 +: 5] ||
                        req_data[i*32 +: 32] !== prev_data[i*32 +: 32]) begin
                        n_fail++;
                        $display("FAIL hold_stable req%0d: addr 0x%0h data 0x%0h, required 0x%0h 0x%0h",
                                 i, req_addr[i*5 +: 5], req_data[i*32 +: 32],
                                 prev_addr[i*5 +: 5], prev_data[i*32 +: 32]);
                    end
                end
            end
            pend      = req_valid & ~req_ready;
            prev_addr = req_addr;
            prev_data = req_data;
        end
    end

    initial begin
        // Row semantics: inputs applied for this cycle; req_ready checked combinationally,
        // registered outputs reflect the previous row's handshake.
        vec[0]  = '{3'b001, {5'd0,5'd0,5'd7}, {64'h0, 32'hDEADBEEF}, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0,        16'd0};
        vec[1]  = '{3'b000, {5'd0,5'd0,5'd7}, {64'h0, 32'hDEADBEEF}, 1'b0, 3'b000, 1'b1, 5'd7, 32'hDEADBEEF, 16'd0};
        vec[2]  = '{3'b100, {5'd3,5'd0,5'd7}, {32'h33,32'h0,32'hDEADBEEF}, 1'b0, 3'b100, 1'b0, 5'd7, 32'hDEADBEEF, 16'd0};
        vec[3]  = '{3'b111, A123, D123, 1'b0, 3'b001, 1'b1, 5'd3, 32'h33, 16'd0};
        vec[4]  = '{3'b111, A123, D123, 1'b0, 3'b010, 1'b1, 5'd1, 32'h11, 16'd1};
        vec[5]  = '{3'b111, A123, D123, 1'b0, 3'b100, 1'b1, 5'd2, 32'h22, 16'd2};
        vec[6]  = '{3'b111, A123, D123, 1'b0, 3'b001, 1'b1, 5'd3, 32'h33, 16'd3};
        vec[7]  = '{3'b000, A123, D123, 1'b0, 3'b000, 1'b1, 5'd1, 32'h11, 16'd4};
        vec[8]  = '{3'b010, {5'd3,5'd0,5'd1}, {32'h33,32'h55,32'h11}, 1'b0, 3'b010, 1'b0, 5'd1, 32'h11, 16'd4};
        vec[9]  = '{3'b111, A123, D123, 1'b0, 3'b100, 1'b0, 5'd0, 32'h55, 16'd4};
        vec[10] = '{3'b101, A123, D123, 1'b1, 3'b000, 1'b1, 5'd3, 32'h33, 16'd5};
        vec[11] = '{3'b101, A123, D123, 1'b1, 3'b000, 1'b0, 5'd3, 32'h33, 16'd6};
        vec[12] = '{3'b101, A123, D123, 1'b1, 3'b000, 1'b0, 5'd3, 32'h33, 16'd7};
        vec[13] = '{3'b101, A123, D123, 1'b1, 3'b000, 1'b0, 5'd3, 32'h33, 16'd8};
        vec[14] = '{3'b101, A123, D123, 1'b0, 3'b001, 1'b0, 5'd3, 32'h33, 16'd9};
        vec[15] = '{3'b101, A123, D123, 1'b0, 3'b100, 1'b1, 5'd1, 32'h11, 16'd10};
        vec[16] = '{3'b000, A123, D123, 1'b0, 3'b000, 1'b1, 5'd3, 32'h33, 16'd11};
        vec[17] = '{3'b000, A123, D123, 1'b0, 3'b000, 1'b0, 5'd3, 32'h33, 16'd11};

        rst_n = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0; wb_hold = 1'b0;
        sat_valid = '0; sat_addr = '0; sat_data = '0; sat_hold = 1'b0;

        #3;
        check("rst_reg_write", 64'(reg_write), 64'd0);
        check("rst_write_reg", 64'(write_reg), 64'd0);
        check("rst_write_data", 64'(write_data), 64'd0);
        check("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
        req_valid = 3'b111;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        #8 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 18; v++) begin
            req_valid = vec[v].valid;
            req_addr  = vec[v].addr;
            req_data  = vec[v].data;
            wb_hold   = vec[v].hold;
            @(negedge clk);
            check($sformatf("v%0d_req_ready", v), 64'(req_ready), 64'(vec[v].ready));
            check($sformatf("v%0d_reg_write", v), 64'(reg_write), 64'(vec[v].rw));
            check($sformatf("v%0d_write_reg", v), 64'(write_reg), 64'(vec[v].wr));
            check($sformatf("v%0d_write_data", v), 64'(write_data), 64'(vec[v].wd));
            check($sformatf("v%0d_conflict_cnt", v), 64'(conflict_cnt), 64'(vec[v].cnt));
            @(posedge clk); #1;
        end

        // Async reset just after a handshake edge; pointer is 1 going into it.
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd9};
        req_data  = {64'h0, 32'hA5A5};
        @(posedge clk); #1;
        check("ar_pre_reg_write", 64'(reg_write), 64'd1);
        check("ar_pre_write_reg", 64'(write_reg), 64'd9);
        #1 rst_n = 1'b0;
        #1;
        check("ar_reg_write", 64'(reg_write), 64'd0);
        check("ar_write_reg", 64'(write_reg), 64'd0);
        check("ar_write_data", 64'(write_data), 64'd0);
        check("ar_conflict_cnt", 64'(conflict_cnt), 64'd0);
        check("ar_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        req_valid = 3'b111;
        req_addr  = A123;
        req_data  = D123;
        @(negedge clk);
        check("ar_post_ptr_grant", 64'(req_ready), 64'b001);
        check("ar_post_reg_write", 64'(reg_write), 64'd0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("ar_post_write_reg", 64'(write_reg), 64'd1);
        check("ar_post_cnt", 64'(conflict_cnt), 64'd1);

        // 4-bit counter saturation.
        @(posedge clk); #1;
        sat_valid = 3'b011;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("sat_cnt_14", 64'(sat_cnt), 64'd14);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("sat_cnt_20", 64'(sat_cnt), 64'd15);
        sat_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
